mux16_scan_sequencer: RTL and testbench
=======================================

Name: mux16_scan_sequencer

Overview:
Sequencing stage wrapped around the 16:1 inverting strobed multiplexer (4 select lines, active-high strobe that forces the output to 1).
- Upstream role: drives the mux select and strobe inputs.
- Downstream role: consumes the single mux output bit.
- Sweeps all 16 channels, samples each after a programmable settle time, checks the forced-disable level, and presents the 16-bit word on a valid/ready interface.

Parameters:
SETTLE, 1, cycles sel_o is held stable before sampling a channel (legal range 0..15).
INVERT, 1, 1: stored bit = ~mux_i (compensates the mux output inversion); 0: stored bit = mux_i.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  scan request; one-cycle pulse or level.
busy_o  out  1  high while in CHECK or SCAN.
sel_o  out  4  mux select; connects to the mux select lines, LSB first.
strobe_o  out  1  mux strobe; 1 forces the mux output to 1 (disabled).
mux_i  in  1  mux output.
word_o  out  16  assembled word; bit k = channel k.
valid_o  out  1  word_o valid.
ready_i  in  1  consumer accepts word_o when valid_o & ready_i.
err_o  out  1  sticky flag: mux_i was 0 while strobe_o was 1.

Behaviour:
Reset values (asynchronous):
- State IDLE; sel_o=0; strobe_o=1; word_o=0; valid_o=0; busy_o=0; err_o=0.
- Internal channel index ch=0 and settle count cnt=0.

States: IDLE, CHECK, SCAN, OUT.

IDLE:
- strobe_o=1.
- start_i=1 -> go to CHECK; clear err_o and word_o.

CHECK (exactly 1 cycle):
- strobe_o=1; sample mux_i.
- If mux_i=0, set err_o.
- Go to SCAN with ch=0, cnt=0.
- err_o remains set until the next accepted start.

SCAN:
- strobe_o=0; sel_o=ch, registered, so it changes on the same edge that updates ch.
- If cnt<SETTLE: cnt++.
- If cnt==SETTLE:
  - word_o[ch] <= INVERT ? ~mux_i : mux_i.
  - cnt <= 0.
  - If ch==15: go to OUT with ch <= 0. Otherwise ch++.
- Each channel takes SETTLE+1 cycles.
- SETTLE=0 samples every cycle.

Latency:
- valid_o rises 2+16*(SETTLE+1) cycles after the edge that accepts start.
- With SETTLE=1 that is 34 cycles.

OUT:
- valid_o=1; strobe_o=1; sel_o holds 15; word_o stable.
- valid_o is not withdrawn without a handshake.
- Handshake (valid_o & ready_i) with start_i=0 -> IDLE, valid_o=0.
- Handshake with start_i=1 -> CHECK directly (back-to-back scans). word_o clears on that edge.

Boundary cases:
- start_i during CHECK, SCAN, or OUT without a handshake is ignored, not queued.
- Reset mid-scan: immediate return to reset values; the partial word is discarded and no valid_o is produced.
- ready_i held high before valid_o: transfer occurs in the first OUT cycle.
- Sample width: ch and sel_o are 4 bits, cnt is 4 bits. ch does not wrap inside SCAN; exit at ch==15 is explicit.

Decomposition:
Shared package mux16_pkg:
- State enum (IDLE, CHECK, SCAN, OUT).
- N_CH=16, SEL_W=4, CNT_W=4.
- Mux strobe polarity constant STROBE_DISABLE=1'b1.

Sub-module mux16_settle_timer:
- Ports: clk, rst, clear, done.
- 4-bit counter; done is asserted when count==SETTLE.
- Instantiated once by the FSM.

Test Plan:
1. Behavioural mux model, data=16'hA5C3, INVERT=1, SETTLE=1; pulse start -> valid_o rises 34 cycles later, word_o=16'hA5C3, err_o=0; sel_o visits 0..15, each held 2 cycles.
2. SETTLE=0, data=16'h8001 -> valid_o after 18 cycles, word_o=16'h8001; SETTLE=3, data=16'h5A5A -> valid_o after 66 cycles, word_o=16'h5A5A.
3. Backpressure: ready_i=0 for 5 cycles after valid_o -> word_o and valid_o stable for 5 cycles; ready_i=1 -> valid_o=0 the next cycle, state IDLE, strobe_o=1.
4. Back-to-back: start_i=1 during handshake, data changes to 16'h1234 -> CHECK next cycle, second word_o=16'h1234 after another 34 cycles, no idle gap.
5. Stuck-low mux model (output 0 while strobe=1) -> err_o=1 from the cycle after CHECK, scan still completes, err_o clears on the next start.
6. Assert rst at channel 7 of a scan -> all outputs at reset values immediately (strobe_o=1, valid_o=0, word_o=0); a new start yields a full correct word 16'hA5C3.

Source files
------------

// File: rtl/mux16_pkg.sv
// Shared types and constants for the 16-channel mux scan sequencer.
package mux16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    // Strobe level that forces the mux output high (mux disabled).
    localparam logic STROBE_DISABLE = 1'b1;

    // Converts the raw mux output into the stored channel bit.
    function automatic logic sample_bit(input logic mux_bit, input bit invert);
        return invert ? ~mux_bit : mux_bit;
    endfunction

endpackage

// File: rtl/mux16_scan_sequencer_if.sv
// Valid/ready word output of the scan sequencer.
interface mux16_scan_sequencer_if;
    import mux16_pkg::*;

    logic [N_CH-1:0] word_o;
    logic            valid_o;
    logic            ready_i;

    modport master (output word_o, output valid_o, input ready_i);
    modport slave  (input word_o, input valid_o, output ready_i);

endinterface

// File: rtl/mux16_settle_timer.sv
// Settle counter: counts up from zero, done when the count reaches SETTLE.
module mux16_settle_timer
    import mux16_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    // Count while running; clear restarts the settle window for the next channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(SETTLE));

endmodule

// File: rtl/mux16_scan_sequencer.sv
// Sweeps a 16:1 inverting strobed mux, checks its disabled level, and
// presents the assembled 16-bit word on a valid/ready interface.
module mux16_scan_sequencer
    import mux16_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter bit INVERT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    strobe_o,
    input  logic                    mux_i,
    output logic                    err_o,
    mux16_scan_sequencer_if.master  bus
);

    state_t          state, state_n;
    logic [SEL_W-1:0] ch;
    logic [N_CH-1:0]  word_q;
    logic            accept;
    logic            settle_clear;
    logic            settle_done;
    logic            last_ch;

    assign last_ch = (ch == SEL_W'(N_CH - 1));

    // The settle window restarts on every sample and is held at zero outside SCAN.
    assign settle_clear = (state != SCAN) || settle_done;

    mux16_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (settle_clear),
        .done  (settle_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; accept marks the edge that launches a new scan.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = CHECK;
                    accept  = 1'b1;
                end
            end
            CHECK: begin
                state_n = SCAN;
            end
            SCAN: begin
                if (settle_done && last_ch) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                if (bus.ready_i) begin
                    if (start_i) begin
                        state_n = CHECK;
                        accept  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Channel index, select, word assembly and sticky disable-level error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch     <= '0;
            sel_o  <= '0;
            word_q <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                word_q <= '0;
                err_o  <= 1'b0;
            end
            if (state == CHECK) begin
                if (mux_i != STROBE_DISABLE) begin
                    err_o <= 1'b1;
                end
                ch    <= '0;
                sel_o <= '0;
            end
            if ((state == SCAN) && settle_done) begin
                word_q[ch] <= sample_bit(mux_i, INVERT);
                if (last_ch) begin
                    // sel_o stays on the last channel while the word is offered.
                    ch <= '0;
                end else begin
                    ch    <= ch + 1'b1;
                    sel_o <= ch + 1'b1;
                end
            end
        end
    end

    assign strobe_o    = (state == SCAN) ? ~STROBE_DISABLE : STROBE_DISABLE;
    assign busy_o      = (state == CHECK) || (state == SCAN);
    assign bus.valid_o = (state == OUT);
    assign bus.word_o  = word_q;

endmodule

// File: tb/tb_mux16_scan_sequencer.sv
// Bench for mux16_scan_sequencer: three instances (SETTLE = 1, 0, 3), each
// driven by a behavioural inverting strobed mux model.
module tb_mux16_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Per-instance stimulus; index 0: SETTLE=1, 1: SETTLE=0, 2: SETTLE=3.
    logic [2:0]  start = '0;
    logic [2:0]  ready = '0;
    logic [2:0]  stuck = '0;
    logic [15:0] data [3];

    wire [2:0]  busy, strobe, err, valid, muxo;
    wire [3:0]  sel  [3];
    wire [15:0] word [3];

    mux16_scan_sequencer_if bus0 ();
    mux16_scan_sequencer_if bus1 ();
    mux16_scan_sequencer_if bus2 ();

    assign bus0.ready_i = ready[0];
    assign bus1.ready_i = ready[1];
    assign bus2.ready_i = ready[2];
    assign valid[0] = bus0.valid_o;
    assign valid[1] = bus1.valid_o;
    assign valid[2] = bus2.valid_o;
    assign word[0]  = bus0.word_o;
    assign word[1]  = bus1.word_o;
    assign word[2]  = bus2.word_o;

    // Mux model: strobe high forces 1 (or 0 when stuck), otherwise the inverted channel bit.
    assign muxo[0] = strobe[0] ? ~stuck[0] : ~data[0][sel[0]];
    assign muxo[1] = strobe[1] ? ~stuck[1] : ~data[1][sel[1]];
    assign muxo[2] = strobe[2] ? ~stuck[2] : ~data[2][sel[2]];

    mux16_scan_sequencer #(.SETTLE(1), .INVERT(1'b1)) u_s1 (
        .clk(clk), .rst(rst), .start_i(start[0]), .busy_o(busy[0]), .sel_o(sel[0]),
        .strobe_o(strobe[0]), .mux_i(muxo[0]), .err_o(err[0]), .bus(bus0.master)
    );
    mux16_scan_sequencer #(.SETTLE(0), .INVERT(1'b1)) u_s0 (
        .clk(clk), .rst(rst), .start_i(start[1]), .busy_o(busy[1]), .sel_o(sel[1]),
        .strobe_o(strobe[1]), .mux_i(muxo[1]), .err_o(err[1]), .bus(bus1.master)
    );
    mux16_scan_sequencer #(.SETTLE(3), .INVERT(1'b1)) u_s3 (
        .clk(clk), .rst(rst), .start_i(start[2]), .busy_o(busy[2]), .sel_o(sel[2]),
        .strobe_o(strobe[2]), .mux_i(muxo[2]), .err_o(err[2]), .bus(bus2.master)
    );

    typedef struct {
        int          inst;
        logic [15:0] data;
        logic [15:0] exp_word;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns just after the accepting edge.
    task automatic start_scan(input int i, input logic [15:0] d);
        data[i]  = d;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    // n counts edges with the accepting edge as 1; bounded.
    task automatic wait_valid(input int i, output int n);
        n = 1;
        while (!valid[i] && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake_idle(input int i);
        ready[i] = 1'b1;
        tick();
        ready[i] = 1'b0;
        chk("hs_valid_low", {31'd0, valid[i]}, 32'd0);
        chk("hs_busy_low", {31'd0, busy[i]}, 32'd0);
        chk("hs_strobe_high", {31'd0, strobe[i]}, 32'd1);
    endtask

    initial begin
        int n;
        data[0] = '0;
        data[1] = '0;
        data[2] = '0;

        vecs[0] = '{inst: 0, data: 16'hA5C3, exp_word: 16'hA5C3, exp_lat: 34};
        vecs[1] = '{inst: 1, data: 16'h8001, exp_word: 16'h8001, exp_lat: 18};
        vecs[2] = '{inst: 2, data: 16'h5A5A, exp_word: 16'h5A5A, exp_lat: 66};
        vecs[3] = '{inst: 0, data: 16'hFFFF, exp_word: 16'hFFFF, exp_lat: 34};
        vecs[4] = '{inst: 1, data: 16'h0000, exp_word: 16'h0000, exp_lat: 18};
        vecs[5] = '{inst: 2, data: 16'h1234, exp_word: 16'h1234, exp_lat: 66};

        // Reset values while rst is held.
        #12;
        chk("rst_strobe", {31'd0, strobe[0]}, 32'd1);
        chk("rst_valid", {31'd0, valid[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_sel", {28'd0, sel[0]}, 32'd0);
        chk("rst_word", {16'd0, word[0]}, 32'd0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven scans.
        for (int v = 0; v < 6; v++) begin
            start_scan(vecs[v].inst, vecs[v].data);
            chk("vec_busy", {31'd0, busy[vecs[v].inst]}, 32'd1);
            wait_valid(vecs[v].inst, n);
            chk("vec_latency", n, vecs[v].exp_lat);
            chk("vec_word", {16'd0, word[vecs[v].inst]}, {16'd0, vecs[v].exp_word});
            chk("vec_err", {31'd0, err[vecs[v].inst]}, 32'd0);
            handshake_idle(vecs[v].inst);
        end

        // Select sweep: each channel held two cycles with strobe low.
        start_scan(0, 16'hA5C3);
        chk("check_strobe", {31'd0, strobe[0]}, 32'd1);
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("sweep_sel", {28'd0, sel[0]}, k / 2);
            chk("sweep_strobe", {31'd0, strobe[0]}, 32'd0);
        end
        tick();
        chk("sweep_valid", {31'd0, valid[0]}, 32'd1);
        chk("sweep_sel_hold", {28'd0, sel[0]}, 32'd15);
        chk("sweep_word", {16'd0, word[0]}, 32'hA5C3);

        // Backpressure: word held for five cycles, then released.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", {31'd0, valid[0]}, 32'd1);
            chk("bp_word", {16'd0, word[0]}, 32'hA5C3);
        end
        handshake_idle(0);

        // Back-to-back: handshake with start goes straight to CHECK.
        start_scan(0, 16'hA5C3);
        wait_valid(0, n);
        chk("b2b_first_word", {16'd0, word[0]}, 32'hA5C3);
        data[0]  = 16'h1234;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ready[0] = 1'b0;
        chk("b2b_busy", {31'd0, busy[0]}, 32'd1);
        chk("b2b_valid_drop", {31'd0, valid[0]}, 32'd0);
        chk("b2b_word_clr", {16'd0, word[0]}, 32'd0);
        wait_valid(0, n);
        chk("b2b_latency", n, 32'd34);
        chk("b2b_word", {16'd0, word[0]}, 32'h1234);
        handshake_idle(0);

        // Stuck-low mux while disabled: sticky error, scan still completes.
        stuck[1] = 1'b1;
        start_scan(1, 16'h00FF);
        chk("stuck_err_in_check", {31'd0, err[1]}, 32'd0);
        tick();
        chk("stuck_err_set", {31'd0, err[1]}, 32'd1);
        wait_valid(1, n);
        chk("stuck_valid", {31'd0, valid[1]}, 32'd1);
        chk("stuck_word", {16'd0, word[1]}, 32'h00FF);
        chk("stuck_err_held", {31'd0, err[1]}, 32'd1);
        stuck[1] = 1'b0;
        data[1]  = 16'h0F0F;
        start[1] = 1'b1;
        ready[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        ready[1] = 1'b0;
        chk("stuck_err_clear", {31'd0, err[1]}, 32'd0);
        wait_valid(1, n);
        chk("stuck_next_word", {16'd0, word[1]}, 32'h0F0F);
        chk("stuck_next_err", {31'd0, err[1]}, 32'd0);
        handshake_idle(1);

        // Reset in the middle of channel 7.
        start_scan(0, 16'hA5C3);
        n = 0;
        while (sel[0] != 4'd7 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reach_ch7", {28'd0, sel[0]}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe", {31'd0, strobe[0]}, 32'd1);
        chk("mid_rst_valid", {31'd0, valid[0]}, 32'd0);
        chk("mid_rst_word", {16'd0, word[0]}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_rst_sel", {28'd0, sel[0]}, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        chk("mid_no_valid", {31'd0, valid[0]}, 32'd0);
        start_scan(0, 16'hA5C3);
        wait_valid(0, n);
        chk("mid_rescan_latency", n, 32'd34);
        chk("mid_rescan_word", {16'd0, word[0]}, 32'hA5C3);
        handshake_idle(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
